pc_gen_unit: RTL and testbench

- Upstream neighbour of fetch_unit. Generates the fetch-group PC (pc_out) that feeds fetch_unit.pc_in.
- Advances by ISSUE_WIDTH*4 bytes per accepted group.
- Holds the PC while fetch is stalled. Applies redirects from branch resolution or exceptions.
- Raises a registered one-cycle flush pulse toward fetch_unit and the instruction queue. Halts once the PC passes the end of the program.

---
 rtl/pc_gen_unit.sv | 128 ++++++++++++
 tb/tb_pc_gen_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: fetch-group PC generator feeding fetch_unit.pc_in.
// Steps ISSUE_WIDTH*4 bytes per unstalled RUN cycle, applies redirects with a
// registered one-cycle flush pulse, and halts once the PC leaves the program.
// Optional build macro PCGEN_PERF_CNT_EN adds saturating performance counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | waiting for fetch to be armed (init_done), PC held
// ST_RUN  | pc_out is a live fetch address, advances when not stalled
// ST_HALT | PC passed the program end; only a redirect leaves
module pc_gen_unit #(
  parameter int          ISSUE_WIDTH = 3,
  parameter int          NO_INSTR    = 33,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  output logic        pc_valid,
  output logic        flush_out,
  output logic        redirect_misaligned,
  output logic [31:0] group_count,
  output logic        halted
`ifdef PCGEN_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_halt_cycles
`endif
);

  localparam logic [31:0] PC_STEP  = 32'(ISSUE_WIDTH * 4);
  localparam logic [31:0] PC_LIMIT = 32'(NO_INSTR * 4);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_d;
  logic [31:0] pc_inc;
  logic [31:0] redirect_tgt;
  logic        advance;

  assign pc_inc       = pc_out + PC_STEP;
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  // Next state and next PC; a redirect outranks stall and the normal advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_out;
    advance = 1'b0;
    if (redirect_valid) begin
      pc_d = redirect_tgt;
      if (!init_done)                  state_d = ST_INIT;
      else if (redirect_tgt < PC_LIMIT) state_d = ST_RUN;
      else                             state_d = ST_HALT;
    end else begin
      case (state_q)
        ST_INIT: begin
          // Compare the held PC so a redirect parked in INIT is range-checked too.
          if (init_done) state_d = (pc_out >= PC_LIMIT) ? ST_HALT : ST_RUN;
        end
        ST_RUN: begin
          if (!stall_in) begin
            pc_d    = pc_inc;
            advance = 1'b1;
            if (pc_inc >= PC_LIMIT) state_d = ST_HALT;
          end
        end
        ST_HALT: ;
        default: state_d = ST_INIT;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    pc_valid = (state_q == ST_RUN);
    halted   = (state_q == ST_HALT);
  end

  // PC, group counter, flush pulse and sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out              <= RESET_PC;
      group_count         <= 32'd0;
      flush_out           <= 1'b0;
      redirect_misaligned <= 1'b0;
    end else begin
      pc_out    <= pc_d;
      flush_out <= redirect_valid;
      if (advance) group_count <= group_count + 32'd1;
      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) redirect_misaligned <= 1'b1;
    end
  end

`ifdef PCGEN_PERF_CNT_EN
  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= 32'd0;
      perf_redirects    <= 32'd0;
      perf_halt_cycles  <= 32'd0;
    end else begin
      if ((state_q == ST_RUN) && stall_in && !redirect_valid && (perf_stall_cycles != 32'hFFFF_FFFF))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (redirect_valid && (perf_redirects != 32'hFFFF_FFFF))
        perf_redirects <= perf_redirects + 32'd1;
      if ((state_q == ST_HALT) && (perf_halt_cycles != 32'hFFFF_FFFF))
        perf_halt_cycles <= perf_halt_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: directed plan steps plus random traffic,
// compared every cycle against a behavioural model of the fetch-PC rules.
module tb_pc_gen_unit;

  localparam int          LIMIT    = 33 * 4;
  localparam int          STEP     = 3 * 4;
  localparam logic [31:0] RST_PC   = 32'h0;

  logic        clk = 1'b0;
  logic        rst, init_done, stall_in, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out, group_count;
  logic        pc_valid, flush_out, redirect_misaligned, halted;
`ifdef PCGEN_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_redirects, perf_halt_cycles;
`endif

  pc_gen_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .init_done           (init_done),
    .stall_in            (stall_in),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .pc_out              (pc_out),
    .pc_valid            (pc_valid),
    .flush_out           (flush_out),
    .redirect_misaligned (redirect_misaligned),
    .group_count         (group_count),
    .halted              (halted)
`ifdef PCGEN_PERF_CNT_EN
    ,
    .perf_stall_cycles   (perf_stall_cycles),
    .perf_redirects      (perf_redirects),
    .perf_halt_cycles    (perf_halt_cycles)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model: mode 0 = waiting for init, 1 = fetching, 2 = past program end.
  int          m_mode;
  longint      m_pc;
  longint      m_groups;
  bit          m_flush, m_mis;
  longint      m_pst, m_prd, m_phl;

  function automatic longint sat_inc(input longint v);
    return (v >= 64'hFFFF_FFFF) ? v : v + 1;
  endfunction

  // Apply the architectural rules for one clock edge to the model.
  task automatic model_edge();
    longint tgt;
    if (rst) begin
      m_mode = 0; m_pc = RST_PC; m_groups = 0; m_flush = 0; m_mis = 0;
      m_pst = 0; m_prd = 0; m_phl = 0;
      return;
    end
    if (m_mode == 1 && stall_in && !redirect_valid) m_pst = sat_inc(m_pst);
    if (redirect_valid) m_prd = sat_inc(m_prd);
    if (m_mode == 2) m_phl = sat_inc(m_phl);
    m_flush = redirect_valid;
    if (redirect_valid) begin
      tgt = longint'(redirect_pc) - (longint'(redirect_pc) % 4);
      if (redirect_pc % 4 != 0) m_mis = 1;
      m_pc = tgt;
      if (!init_done)      m_mode = 0;
      else if (tgt < LIMIT) m_mode = 1;
      else                 m_mode = 2;
    end else if (m_mode == 0) begin
      if (init_done) m_mode = (m_pc >= LIMIT) ? 2 : 1;
    end else if (m_mode == 1 && !stall_in) begin
      m_pc = (m_pc + STEP) % (64'd1 << 32);
      m_groups = m_groups + 1;
      if (m_pc >= LIMIT) m_mode = 2;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    vectors++;
    check("pc_out",      pc_out,                      32'(m_pc));
    check("pc_valid",    {31'd0, pc_valid},           32'(m_mode == 1));
    check("halted",      {31'd0, halted},             32'(m_mode == 2));
    check("flush_out",   {31'd0, flush_out},          32'(m_flush));
    check("misaligned",  {31'd0, redirect_misaligned}, 32'(m_mis));
    check("group_count", group_count,                 32'(m_groups));
`ifdef PCGEN_PERF_CNT_EN
    check("perf_stall",  perf_stall_cycles,           32'(m_pst));
    check("perf_redir",  perf_redirects,              32'(m_prd));
    check("perf_halt",   perf_halt_cycles,            32'(m_phl));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit r, input bit id, input bit st, input bit rv, input logic [31:0] rp);
    rst = r; init_done = id; stall_in = st; redirect_valid = rv; redirect_pc = rp;
  endtask

  initial begin
    m_mode = 0; m_pc = 0; m_groups = 0; m_flush = 0; m_mis = 0;
    m_pst = 0; m_prd = 0; m_phl = 0;

    // Reset for two cycles, arm fetch on the third, free-run to the end.
    drive(1, 0, 0, 0, 0);
    tick();
    check("rst_pc", pc_out, 32'h0);
    check("rst_valid", {31'd0, pc_valid}, 32'd0);
    tick();
    drive(0, 1, 0, 0, 0);
    tick();
    check("run_start_pc", pc_out, 32'd0);
    check("run_start_valid", {31'd0, pc_valid}, 32'd1);
    for (int i = 1; i <= 11; i++) begin
      tick();
      check("seq_pc", pc_out, 32'(i * 12));
    end
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_valid", {31'd0, pc_valid}, 32'd0);
    check("halt_groups", group_count, 32'd11);
    tick();
    check("halt_hold", pc_out, 32'd132);

    // Redirect back to 0, advance to 24, stall 4 cycles, release.
    drive(0, 1, 0, 1, 32'h0);
    tick();
    check("redir0_flush", {31'd0, flush_out}, 32'd1);
    drive(0, 1, 0, 0, 0);
    tick();
    tick();
    check("pre_stall_pc", pc_out, 32'd24);
    drive(0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_pc", pc_out, 32'd24);
      check("stall_groups", group_count, 32'd13);
    end
    drive(0, 1, 0, 0, 0);
    tick();
    check("release_pc", pc_out, 32'd36);

    // Redirect beats stall.
    drive(0, 1, 1, 1, 32'h40);
    tick();
    check("redir_stall_pc", pc_out, 32'h40);
    check("redir_stall_flush", {31'd0, flush_out}, 32'd1);
    drive(0, 1, 1, 0, 0);
    tick();
    check("flush_one_cycle", {31'd0, flush_out}, 32'd0);
    drive(0, 1, 0, 0, 0);
    tick();
    check("after_redir_pc", pc_out, 32'h4C);

    for (int i = 0; i < 20 && m_mode != 2; i++) tick();
    check("reach_halt", {31'd0, halted}, 32'd1);

    // Misaligned redirect out of HALT, then back-to-back redirects.
    drive(0, 1, 0, 1, 32'h0A);
    tick();
    check("mis_pc", pc_out, 32'h08);
    check("mis_flag", {31'd0, redirect_misaligned}, 32'd1);
    check("mis_run", {31'd0, pc_valid}, 32'd1);
    drive(0, 1, 0, 1, 32'h200);
    tick();
    check("far_halt", {31'd0, halted}, 32'd1);
    check("far_flush", {31'd0, flush_out}, 32'd1);
    drive(0, 1, 0, 1, 32'h10);
    tick();
    drive(0, 1, 0, 1, 32'h14);
    tick();
    check("b2b_flush", {31'd0, flush_out}, 32'd1);
    check("b2b_pc", pc_out, 32'h14);
    check("mis_sticky", {31'd0, redirect_misaligned}, 32'd1);
    drive(0, 0, 0, 1, 32'h20);
    tick();
    check("redir_init_valid", {31'd0, pc_valid}, 32'd0);
    drive(0, 1, 0, 0, 0);
    tick();
    check("init_to_run_pc", pc_out, 32'h20);

    // Reset wins over a simultaneous redirect.
    drive(1, 1, 0, 1, 32'h30);
    tick();
    check("rst_redir_pc", pc_out, 32'h0);
    check("rst_redir_flush", {31'd0, flush_out}, 32'd0);
    check("rst_redir_mis", {31'd0, redirect_misaligned}, 32'd0);

`ifdef PCGEN_PERF_CNT_EN
    // 5 stall cycles, 2 redirects, 3 HALT cycles.
    drive(0, 1, 0, 0, 0);
    tick();
    drive(0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    drive(0, 1, 0, 1, 32'h10);
    tick();
    drive(0, 1, 0, 1, 32'h200);
    tick();
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    check("perf_stall_5", perf_stall_cycles, 32'd5);
    check("perf_redir_2", perf_redirects, 32'd2);
    check("perf_halt_3", perf_halt_cycles, 32'd3);
    drive(1, 0, 0, 0, 0);
    tick();
    check("perf_rst", perf_stall_cycles | perf_redirects | perf_halt_cycles, 32'd0);
`endif

    // Random traffic against the model.
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rp;
      case ($urandom_range(0, 3))
        0:       rp = $urandom;
        1:       rp = 32'($urandom_range(0, 140));
        default: rp = 32'($urandom_range(0, 33)) * 4;
      endcase
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 19) != 0,
            $urandom_range(0, 99) < 30, $urandom_range(0, 9) == 0, rp);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
